// File: rtl/lfsr_word_ctrl.sv
// lfsr_word_ctrl: sequences a serial LFSR core and packs its output bits into words
// Rev 1.0 - initial release
`default_nettype none

module lfsr_word_ctrl #(
  parameter int WORD_W = 8,
  parameter int SEED_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [SEED_W-1:0] Seed,
  input  logic [CNT_W-1:0]  Num_Words,
  input  logic              Abort,
  output logic              Busy,
  output logic              Lfsr_Load,
  output logic [SEED_W-1:0] Lfsr_Seed,
  output logic              Lfsr_En,
  input  logic              Lfsr_Out,
  output logic [WORD_W-1:0] Word_Data,
  output logic              Word_Valid,
  input  logic              Word_Ready,
  output logic              Done
);

  localparam int BIT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] ONE_WORD = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [BIT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] word_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      Busy       <= 1'b0;
      Lfsr_Load  <= 1'b0;
      Lfsr_Seed  <= '0;
      Lfsr_En    <= 1'b0;
      Word_Data  <= '0;
      Word_Valid <= 1'b0;
      Done       <= 1'b0;
    end else if (Abort && (state != S_IDLE)) begin
      // A handshake coinciding with Abort still completes on the consumer side.
      state      <= S_IDLE;
      Busy       <= 1'b0;
      Lfsr_Load  <= 1'b0;
      Lfsr_En    <= 1'b0;
      Word_Valid <= 1'b0;
      Done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            Lfsr_Seed <= Seed;
            word_cnt  <= Num_Words;
            Busy      <= 1'b1;
            if (Num_Words == '0) begin
              state <= S_DONE;
              Done  <= 1'b1;
            end else begin
              state     <= S_LOAD;
              Lfsr_Load <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          Lfsr_Load <= 1'b0;
          Lfsr_En   <= 1'b1;
          bit_cnt   <= '0;
          state     <= S_SHIFT;
        end
        S_SHIFT: begin
          // The first bit of a word ends up in the MSB.
          Word_Data <= {Word_Data[WORD_W-2:0], Lfsr_Out};
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            Lfsr_En    <= 1'b0;
            Word_Valid <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (Word_Ready) begin
            Word_Valid <= 1'b0;
            word_cnt   <= word_cnt - 1'b1;
            if (word_cnt == ONE_WORD) begin
              Done  <= 1'b1;
              state <= S_DONE;
            end else begin
              bit_cnt <= '0;
              Lfsr_En <= 1'b1;
              state   <= S_SHIFT;
            end
          end
        end
        S_DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          Busy       <= 1'b0;
          Lfsr_Load  <= 1'b0;
          Lfsr_En    <= 1'b0;
          Word_Valid <= 1'b0;
          Done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lfsr_word_ctrl.sv
// tb_lfsr_word_ctrl: directed bursts against an LFSR stub, words and Done checked by a scoreboard
`default_nettype none

module tb_lfsr_word_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  Seed = '0;
  logic [15:0] Num_Words = '0;
  logic        Abort = 1'b0;
  logic        Busy;
  logic        Lfsr_Load;
  logic [7:0]  Lfsr_Seed;
  logic        Lfsr_En;
  logic        Lfsr_Out;
  logic [7:0]  Word_Data;
  logic        Word_Valid;
  logic        Word_Ready = 1'b0;
  logic        Done;

  lfsr_word_ctrl #(.WORD_W(8), .SEED_W(8), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Seed(Seed), .Num_Words(Num_Words),
    .Abort(Abort), .Busy(Busy), .Lfsr_Load(Lfsr_Load), .Lfsr_Seed(Lfsr_Seed),
    .Lfsr_En(Lfsr_En), .Lfsr_Out(Lfsr_Out), .Word_Data(Word_Data),
    .Word_Valid(Word_Valid), .Word_Ready(Word_Ready), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // LFSR stub: load seed, shift right with zero fill, serial output is bit 0.
  logic [7:0] core = '0;
  always @(posedge Clk) begin
    if (Lfsr_Load)    core <= Lfsr_Seed;
    else if (Lfsr_En) core <= core >> 1;
  end
  assign Lfsr_Out = core[0];

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t wq[$];
  int   dq[$];

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int t0 = 0;
  bit armed = 1'b0;

  int en_cnt, load_cnt, load_cyc, valid_cnt, last_busy, en_valid, rel;
  logic       prev_valid = 1'b0;
  logic       prev_hs = 1'b0;
  logic [7:0] prev_data = '0;

  always @(posedge Clk) cycle++;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge Clk) begin
    if (armed) begin
      rel = cycle - t0;
      if (Lfsr_En) en_cnt++;
      if (Lfsr_Load) begin
        load_cnt++;
        load_cyc = rel;
      end
      if (Word_Valid) valid_cnt++;
      if (Word_Valid && Lfsr_En) en_valid++;
      if (Busy) last_busy = rel;
      if (Word_Valid && prev_valid && !prev_hs)
        chk("hold_stable", int'(Word_Data), int'(prev_data));
      if (Word_Valid && Word_Ready) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_word: got 0x%0h at cycle %0d, expected none", Word_Data, rel);
        end else begin
          exp_t e;
          e = wq.pop_front();
          chk("word_data", int'(Word_Data), int'(e.data));
          chk("word_cycle", rel, e.cyc);
        end
      end
      if (Done) begin
        if (dq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got Done at cycle %0d, expected none", rel);
        end else begin
          chk("done_cycle", rel, dq.pop_front());
        end
      end
      prev_valid = Word_Valid;
      prev_data  = Word_Data;
      prev_hs    = Word_Valid && Word_Ready;
    end
  end

  function automatic int outs_packed();
    return int'({Busy, Lfsr_Load, Lfsr_En, Word_Valid, Done, Lfsr_Seed, Word_Data});
  endfunction

  task automatic push_word(input logic [7:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    wq.push_back(e);
  endtask

  // Runs one burst for ncyc cycles; Start is driven in relative cycle 0.
  task automatic burst(input logic [7:0] sd, input logic [15:0] n, input int stall,
                       input int abort_at, input int reset_at, input bit busy_starts,
                       input int ncyc);
    t0 = cycle;
    en_cnt = 0; load_cnt = 0; load_cyc = -1; valid_cnt = 0; last_busy = -1; en_valid = 0;
    for (int c = 0; c < ncyc; c++) begin
      Start      = (c == 0) || (busy_starts && (c == 4 || c == 11));
      Seed       = (c == 0) ? sd : 8'h5A;
      Num_Words  = (c == 0) ? n : 16'd7;
      Abort      = (c == abort_at);
      Reset      = (c == reset_at);
      Word_Ready = !(c >= 10 && c < 10 + stall);
      @(posedge Clk); #1;
      if (c == reset_at) chk("reset_mid_hold_outputs", outs_packed(), 0);
    end
    Start = 1'b0; Abort = 1'b0; Reset = 1'b0; Word_Ready = 1'b0;
  endtask

  task automatic end_chk(input int e_en, input int e_load, input int e_load_cyc,
                         input int e_valid, input int e_last_busy);
    chk("en_cycles", en_cnt, e_en);
    chk("load_count", load_cnt, e_load);
    chk("load_cycle", load_cyc, e_load_cyc);
    chk("valid_cycles", valid_cnt, e_valid);
    chk("last_busy_cycle", last_busy, e_last_busy);
    chk("en_during_valid", en_valid, 0);
    chk("words_pending", wq.size(), 0);
    chk("done_pending", dq.size(), 0);
    wq.delete();
    dq.delete();
  endtask

  initial begin
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_outputs", outs_packed(), 0);
    Reset = 1'b0;
    @(posedge Clk); #1;
    armed = 1'b1;

    // Basic single-word burst
    push_word(8'h80, 10); dq.push_back(11);
    burst(8'h01, 16'd1, 0, -1, -1, 1'b0, 16);
    end_chk(8, 1, 1, 1, 11);

    // Two words with five cycles of back-pressure on the first
    push_word(8'hC3, 15); push_word(8'h00, 24); dq.push_back(25);
    burst(8'hC3, 16'd2, 5, -1, -1, 1'b0, 30);
    end_chk(16, 1, 1, 7, 25);

    // Zero-length request
    dq.push_back(1);
    burst(8'hAA, 16'd0, 0, -1, -1, 1'b0, 6);
    end_chk(0, 0, -1, 0, 1);

    // Abort in SHIFT, then a clean burst
    burst(8'h01, 16'd1, 0, 5, -1, 1'b0, 12);
    end_chk(4, 1, 1, 0, 5);
    push_word(8'h80, 10); dq.push_back(11);
    burst(8'h01, 16'd1, 0, -1, -1, 1'b0, 14);
    end_chk(8, 1, 1, 1, 11);

    // Start pulses while busy (cycles 4 and 11) must be ignored
    push_word(8'h80, 10); dq.push_back(11);
    burst(8'h01, 16'd1, 0, -1, -1, 1'b1, 20);
    end_chk(8, 1, 1, 1, 11);
    chk("seed_after_busy_starts", int'(Lfsr_Seed), 8'h01);

    // Abort together with Start in IDLE: Start wins
    push_word(8'h80, 10); dq.push_back(11);
    burst(8'h01, 16'd1, 0, 0, -1, 1'b0, 14);
    end_chk(8, 1, 1, 1, 11);

    // Synchronous reset while holding a word
    burst(8'h01, 16'd1, 100, -1, 10, 1'b0, 14);
    end_chk(8, 1, 1, 1, 10);
    push_word(8'h80, 10); dq.push_back(11);
    burst(8'h01, 16'd1, 0, -1, -1, 1'b0, 14);
    end_chk(8, 1, 1, 1, 11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
